// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Four-source interrupt controller. Edge-detects raw requests
//                into pending bits, holds the enable/status register, presents
//                one prioritised request and vector to the core, and tracks
//                the in-service interrupt until RTI.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter logic [15:0] INT_EN_AD = 16'hC002,
    parameter logic [15:0] VEC0      = 16'h0010,
    parameter logic [15:0] VEC1      = 16'h0020,
    parameter logic [15:0] VEC2      = 16'h0030,
    parameter logic [15:0] VEC3      = 16'h0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irq,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        int_req,
    output logic [15:0] int_vec,
    input  logic        int_ack,
    input  logic        rti
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_irq_q;
    logic [3:0]  r_pending;
    logic [3:0]  r_en;
    logic        r_gie;
    logic [1:0]  r_id;
    logic        r_int_req;
    logic [15:0] r_int_vec;

    logic        w_wr;
    logic [3:0]  w_set;
    logic [3:0]  w_w1c;
    logic        w_ack;
    logic [3:0]  w_ack_clr;
    logic [3:0]  w_masked;
    logic [1:0]  w_sel_id;
    logic [15:0] w_sel_vec;
    logic        w_in_svc;
    logic        w_unused_wdata;

    assign w_wr      = we && (addr == INT_EN_AD);
    assign w_set     = irq & ~r_irq_q;
    assign w_w1c     = w_wr ? wdata[11:8] : 4'b0000;
    // int_ack only counts while a request is outstanding
    assign w_ack     = (r_state == S_REQ) && int_ack;
    assign w_ack_clr = w_ack ? (4'b0001 << r_id) : 4'b0000;
    assign w_masked  = r_pending & r_en;
    assign w_in_svc  = (r_state == S_SERVICE);

    // Bits of the write word that carry no register field
    assign w_unused_wdata = ^{wdata[15:12], wdata[6:4]};

    // Fixed priority: lowest enabled pending index wins
    always_comb begin
        w_sel_id  = 2'd0;
        w_sel_vec = VEC0;
        if (w_masked[0]) begin
            w_sel_id  = 2'd0;
            w_sel_vec = VEC0;
        end else if (w_masked[1]) begin
            w_sel_id  = 2'd1;
            w_sel_vec = VEC1;
        end else if (w_masked[2]) begin
            w_sel_id  = 2'd2;
            w_sel_vec = VEC2;
        end else if (w_masked[3]) begin
            w_sel_id  = 2'd3;
            w_sel_vec = VEC3;
        end
    end

    // Edge capture, pending bookkeeping (set beats clear) and enable register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q   <= 4'b0000;
            r_pending <= 4'b0000;
            r_en      <= 4'b0000;
            r_gie     <= 1'b0;
        end else begin
            r_irq_q   <= irq;
            r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_set;
            if (w_wr) begin
                r_en  <= wdata[3:0];
                r_gie <= wdata[7];
            end
        end
    end

    // Request handshake: arbitrate in IDLE, hold in REQ, wait for RTI in SERVICE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_id      <= 2'd0;
            r_int_req <= 1'b0;
            r_int_vec <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_gie && (|w_masked)) begin
                        r_id      <= w_sel_id;
                        r_int_vec <= w_sel_vec;
                        r_int_req <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        r_int_req <= 1'b0;
                        r_int_vec <= 16'h0000;
                        r_state   <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (rti) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_int_req <= 1'b0;
                    r_int_vec <= 16'h0000;
                end
            endcase
        end
    end

    assign int_req = r_int_req;
    assign int_vec = r_int_vec;
    assign rdata   = (re && (addr == INT_EN_AD))
                   ? {w_in_svc, 3'b000, r_pending, r_gie, 3'b000, r_en}
                   : 16'h0000;

endmodule
`default_nettype wire
